// File: rtl/lz_normalizer.sv
// Sequential left-normalizer: shifts an operand left until its leading one reaches the MSB.
// Optional build macro NORM_FAST_STEP_EN enables 4-position steps while enough shift remains.
module lz_normalizer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned POS_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [POS_W-1:0] in_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [POS_W-1:0] out_shamt,
    output logic             out_zero,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [POS_W-1:0] FullPos = POS_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [POS_W-1:0] shamt_q, shamt_d;
    logic [POS_W-1:0] rem_q, rem_d;
    logic             zero_q, zero_d;
    logic [POS_W-1:0] step;
    logic [POS_W-1:0] pos_eff;

    always_comb begin
`ifdef NORM_FAST_STEP_EN
        step = (rem_q >= POS_W'(4)) ? POS_W'(4) : POS_W'(1);
`else
        step = POS_W'(1);
`endif
    end

    // Out-of-range indices are clamped so the operand passes through unshifted.
    assign pos_eff = (in_pos > FullPos) ? FullPos : in_pos;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_pos == '0) begin
                        data_d  = '0;
                        shamt_d = '0;
                        zero_d  = 1'b1;
                        rem_d   = '0;
                        state_d = StDone;
                    end else begin
                        data_d  = in_data;
                        shamt_d = '0;
                        zero_d  = 1'b0;
                        rem_d   = FullPos - pos_eff;
                        state_d = (rem_d == '0) ? StDone : StShift;
                    end
                end
            end
            StShift: begin
                data_d  = data_q << step;
                shamt_d = shamt_q + step;
                rem_d   = rem_q - step;
                if (rem_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            shamt_q <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_lz_normalizer.sv
// Self-checking bench for lz_normalizer: directed cases plus random requests against a
// shift-by-index reference model.
module tb_lz_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_pos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_shamt;
    logic        out_zero;
    logic        busy;

    int passed = 0;
    int total  = 0;

    lz_normalizer #(.WIDTH(32), .POS_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pos    (in_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Reference model: shift count is 32 minus the clamped index; zero index means zero operand.
    function automatic int model_rem(input logic [5:0] p);
        if (p == 6'd0 || p > 6'd32) return 0;
        return 32 - int'(p);
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] d, input logic [5:0] p);
        if (p == 6'd0) return 32'h0;
        return d << model_rem(p);
    endfunction

    function automatic int model_lat(input logic [5:0] p);
        int r;
        r = model_rem(p);
`ifdef NORM_FAST_STEP_EN
        return r / 4 + r % 4 + 1;
`else
        return r + 1;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_shamt"}, 32'(out_shamt), 32'd0);
        check({tag, "_out_zero"}, 32'(out_zero), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; holds the result for 'hold' cycles before consuming.
    task automatic run_req(input string tag, input logic [31:0] d, input logic [5:0] p,
                           input int hold);
        int lat;
        logic seen;
        logic [31:0] exp_d;
        exp_d = model_data(d, p);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_pos   = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_pos   = 6'($urandom_range(0, 63));
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(model_lat(p)));
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_shamt"}, 32'(out_shamt), 32'(model_rem(p)));
        check({tag, "_zero"}, 32'(out_zero), 32'(p == 6'd0));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        // A competing request during DONE must be ignored.
        in_valid = 1'b1;
        in_data  = ~d;
        in_pos   = p ^ 6'd1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_data"}, out_data, exp_d);
            check({tag, "_hold_shamt"}, 32'(out_shamt), 32'(model_rem(p)));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_consumed_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_consumed_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_consumed_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pos    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        run_req("msb_set", 32'h8000_0000, 6'd32, 0);
        run_req("lsb_only", 32'h0000_0001, 6'd1, 0);
        run_req("zero", 32'h0000_0000, 6'd0, 0);
        run_req("mid_hold", 32'h0001_2345, 6'd17, 5);

        // Reset in the middle of SHIFT discards the request.
        in_valid = 1'b1;
        in_data  = 32'h0000_00F0;
        in_pos   = 6'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_shift_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        run_req("illegal_pos", 32'h1234_5678, 6'd40, 0);
        run_req("pos_63", 32'hDEAD_BEEF, 6'd63, 1);
        run_req("pos_31", 32'h4000_0000, 6'd31, 0);
        run_req("pos_4", 32'h0000_000A, 6'd4, 0);
        run_req("mismatch", 32'hFFFF_FFFF, 6'd20, 2);

        for (int n = 0; n < 20; n++) begin
            logic [31:0] rd;
            logic [5:0]  rp;
            rd = $urandom;
            rp = 6'($urandom_range(0, 63));
            run_req("random", rd, rp, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lz_normalizer.md
# lz_normalizer

- Sequential left-normalizer placed directly downstream of the one-hot-to-index encoder in the RISC datapath.
- Accepts a 32-bit operand together with the 1-based index of its leading one: 1..32, or 0 for an all-zero operand.
- Shifts the operand left iteratively until bit 31 is set.
- Returns the normalized word and the shift amount over a valid/ready handshake, for use by normalize/count-leading-zero style instructions.

## Interface
- WIDTH, 32, operand width; the design is only required to be correct at 32.
- POS_W, 6, width of the leading-one index and of the shift amount.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_data  in  WIDTH  operand.
- in_pos  in  POS_W  1-based leading-one index from the encoder; 0 means the operand is zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  normalized operand.
- out_shamt  out  POS_W  number of positions shifted, 0..31.
- out_zero  out  1  operand was zero.
- busy  out  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: in_ready=1; out_valid=0; out_data=0; out_shamt=0; out_zero=0; busy=0.
- Accept: in_valid && in_ready at a rising edge. in_data and in_pos are sampled only on that edge.
- On accept, the remaining count is computed as rem = 32 − in_pos, using a 6-bit unsigned result.
- in_pos = 0:
  - out_data=0, out_shamt=0, out_zero=1.
  - Next state is DONE.
- in_pos in 33..63 (illegal):
  - Treated as 32, so rem=0.
  - The operand passes through unchanged with out_zero=0.
- in_pos in 1..32:
  - Load out_data=in_data, out_shamt=0, out_zero=0.
  - If rem=0, go to DONE; otherwise go to SHIFT.
- SHIFT: each cycle, out_data <<= step, out_shamt += step, rem −= step.
  - step = 1 by default.
  - When rem reaches 0, go to DONE on the same edge.
- DONE:
  - out_valid=1; out_data, out_shamt and out_zero are held stable.
  - On out_valid && out_ready, go to IDLE and drop out_valid.
- Results are not checked against in_data; the encoder's index is authoritative. In_pos that disagrees with in_data shifts exactly rem positions.
- The block holds one request at a time. A new request is not accepted in the cycle a result is consumed; in_ready rises the cycle after.

## Timing
- Accept at edge k with rem=r and the default step: out_valid rises after edge k+r+1, i.e. r+1 cycles of latency.
- Zero operands and rem=0 operands: out_valid is high 1 cycle after the accept edge.
- Back-to-back throughput: one result per (latency + 1) cycles when out_ready is held high.
- out_ready low holds DONE indefinitely. Outputs stay constant and in_ready stays 0.
- Asserting rst in any state clears all state immediately to the reset values. A request that is in flight is discarded.
- in_valid is ignored outside IDLE. No data is captured and no error is raised.

## Configuration
- NORM_FAST_STEP_EN: when defined, SHIFT uses step = 4 while rem ≥ 4, else step = 1.
  - SHIFT then lasts floor(r/4) + (r mod 4) cycles.
  - Final out_data and out_shamt are identical to the default build.
- Undefined: step is always 1, with the latency given under Timing.

## Test plan
- in_data=0x8000_0000, in_pos=32:
  - Expect out_data=0x8000_0000, out_shamt=0, out_zero=0.
  - Expect out_valid 1 cycle after accept.
- in_data=0x0000_0001, in_pos=1:
  - Expect out_data=0x8000_0000, out_shamt=31.
  - Expect out_valid 32 cycles after accept, or 11 cycles with NORM_FAST_STEP_EN (7+3 shift cycles).
- in_data=0, in_pos=0:
  - Expect out_data=0, out_shamt=0, out_zero=1, out_valid 1 cycle after accept.
- in_data=0x0001_2345, in_pos=17:
  - Expect out_data=0x91A2_8000, out_shamt=15.
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, a second in_valid is ignored.
  - Release out_ready: result consumed, in_ready=1 on the next cycle.
- in_data=0x0000_00F0, in_pos=8, then rst=0 for 1 cycle during SHIFT:
  - Expect all outputs at reset values and IDLE after release.
  - Then in_pos=40 with in_data=0x1234_5678: expect pass-through, out_shamt=0, out_zero=0.
